seg7_scan_driver: RTL and testbench
===================================

# seg7_scan_driver

Time-multiplexed driver for a bank of common-anode 7-segment digits: the parametrised successor to the single-digit 74LS47 BCD decoder path in the digital clock. It takes DIGITS packed BCD nibbles and decimal points, double-buffers them so an update never tears a frame, and scans one digit at a time. It applies 74LS47 glyphs, ripple-blanking of leading zeros and lamp test. It sits between the clock/time-keeping counters and the display pins.

## Interface
- DIGITS, 4, number of digits scanned (1..8)
- SCAN_DIV, 1000, clk cycles per digit slot (>= 2)
- ACTIVE_LOW, 1, 1: seg/dp/an pins active-low; 0: active-high
- clk  in  1  system clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- bcd_in  in  4*DIGITS  packed BCD, digit 0 = bcd_in[3:0] (least significant)
- dp_in  in  DIGITS  decimal point per digit
- load  in  1  one-cycle strobe: capture bcd_in/dp_in into pending buffer
- blank_zero  in  1  enable leading-zero suppression (RBI equivalent)
- lamp_test  in  1  force all segments and dp lit
- seg  out  7  segments {g,f,e,d,c,b,a}
- dp  out  1  decimal point of scanned digit
- an  out  DIGITS  one-hot digit enable
- frame_done  out  1  one-cycle pulse at each frame boundary

## Operation
- Counters: div 0..SCAN_DIV-1; idx 0..DIGITS-1, advanced when div wraps; idx wraps DIGITS-1 -> 0 = frame boundary.
- Buffers: pending written on load; active <= pending at each frame boundary. load coincident with a boundary writes bcd_in/dp_in straight into active and pending.
- Decode (74LS47-compatible, active segments): 0 abcdef, 1 bc, 2 abdeg, 3 abcdg, 4 bcfg, 5 acdfg, 6 cdefg, 7 abc, 8 abcdefg, 9 abcfg, 10 deg, 11 cdg, 12 bfg, 13 adfg, 14 defg, 15 blank.
- Leading-zero blanking: when blank_zero=1, digit i (i>0) is blanked if it and every digit above it in active are 0. Digit 0 never blanked. Blanked digit: seg off, dp still follows dp_in.
- lamp_test overrides decode and blanking: all seg and dp on; scanning continues.
- Ghost guard: an all-off in the first cycle (div==0) of every slot.
- Polarity: ACTIVE_LOW inverts seg, dp, an at the output registers only.

## Timing
- Reset values: div=0, idx=0, pending=active=0, seg/dp/an all inactive (all 1s when ACTIVE_LOW), frame_done=0.
- All outputs are registered from the current counters/active state: 1-cycle latency.
- Slot k occupies SCAN_DIV cycles; an shows digit k for SCAN_DIV-1 of them, one cycle after the counters enter/leave the slot.
- Frame = DIGITS*SCAN_DIV cycles; frame_done high exactly one cycle, registered, in the cycle after idx wraps to 0.
- New data is visible from the first slot of the frame after the load: a latency of up to one frame plus 1 cycle, never mid-frame.
- Multiple loads within one frame: last one wins.
- rst mid-frame: outputs go inactive immediately (async), and the buffers clear. After release, scanning restarts at digit 0, div 0.

## Structure
- Package seg7_pkg: segment bit index constants (SEG_A..SEG_G), the 16-entry glyph table above, and an idx width localparam rule (max(1, clog2(DIGITS))).
- Sub-module seg7_decode: combinational 4-bit code + blank + lamp_test -> 7 active-high segments. One instance, fed by a digit mux on idx. Polarity is applied in the top.

## Test plan
Bench: DIGITS=4, SCAN_DIV=4, ACTIVE_LOW=1.
- Reset held, then released -> seg=7'h7F, dp=1, an=4'hF, frame_done=0; first an=4'hE appears 2 cycles after first slot begins.
- load 16'h1234, blank_zero=0 -> next frame: an=E seg=7'h19 ('4'), an=D '3', an=B '2', an=7 seg=7'h79 ('1'); frame_done every 16 cycles.
- load 16'h0070, blank_zero=1 -> digits 3,2 seg=7'h7F; digit 1 seg=7'h78 ('7'); digit 0 seg=7'h40 ('0', not blanked); with blank_zero=0 digits 3,2 show 7'h40.
- load 16'h1111 mid-frame while showing 16'h8888 -> rest of frame still shows '8' (7'h00), next frame all '1'. Also load on the boundary cycle -> same frame shows new value.
- lamp_test=1 with 16'hFFFF (code 15 = blank) -> seg=7'h00, dp=0 on every slot; lamp_test=0 -> seg=7'h7F.
- rst asserted mid-slot 2 -> outputs inactive that same cycle; after release, scan restarts at an=E with active data 0.

Source files
------------

// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared constants, glyph table and sizing helper for the 7-segment scan driver
package seg7_pkg;

    // Bit positions inside a segment vector {g,f,e,d,c,b,a}
    localparam int SEG_A = 0;
    localparam int SEG_B = 1;
    localparam int SEG_C = 2;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_F = 5;
    localparam int SEG_G = 6;

    // 74LS47 glyphs, active-high; codes 10..14 are the odd 74LS47 shapes, 15 is blank
    localparam logic [6:0] GLYPH_TABLE [16] = '{
        7'h3F,  // 0  abcdef
        7'h06,  // 1  bc
        7'h5B,  // 2  abdeg
        7'h4F,  // 3  abcdg
        7'h66,  // 4  bcfg
        7'h6D,  // 5  acdfg
        7'h7C,  // 6  cdefg
        7'h07,  // 7  abc
        7'h7F,  // 8  abcdefg
        7'h67,  // 9  abcfg
        7'h58,  // 10 deg
        7'h4C,  // 11 cdg
        7'h62,  // 12 bfg
        7'h69,  // 13 adfg
        7'h78,  // 14 defg
        7'h00   // 15 blank
    };

    // Digit index width; a single-digit bank still gets a 1-bit index
    function automatic int idx_width(input int digits);
        return (digits > 1) ? $clog2(digits) : 1;
    endfunction

endpackage

// File: rtl/seg7_scan_driver_if.sv
// rtl/seg7_scan_driver_if.sv - data/control inputs and display pins of the scan driver
interface seg7_scan_driver_if #(
    parameter int DIGITS = 4
);
    logic [4*DIGITS-1:0] bcd_in;
    logic [DIGITS-1:0]   dp_in;
    logic                load;
    logic                blank_zero;
    logic                lamp_test;
    logic [6:0]          seg;
    logic                dp;
    logic [DIGITS-1:0]   an;
    logic                frame_done;

    modport master (
        output bcd_in, dp_in, load, blank_zero, lamp_test,
        input  seg, dp, an, frame_done
    );

    modport slave (
        input  bcd_in, dp_in, load, blank_zero, lamp_test,
        output seg, dp, an, frame_done
    );
endinterface

// File: rtl/seg7_decode.sv
// rtl/seg7_decode.sv - 4-bit code to active-high 74LS47 segments with blank and lamp test
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] i_code,
    input  logic       i_blank,
    input  logic       i_lamp_test,
    output logic [6:0] o_seg
);

    // Lamp test beats blanking, blanking beats the glyph
    always_comb begin
        o_seg = GLYPH_TABLE[i_code];
        if (i_blank) begin
            o_seg = '0;
        end
        if (i_lamp_test) begin
            o_seg = '1;
        end
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - double-buffered multiplexed driver for a bank of 7-segment digits
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int DIGITS     = 4,
    parameter int SCAN_DIV   = 1000,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    seg7_scan_driver_if.slave    bus
);

    localparam int IDX_W = idx_width(DIGITS);
    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);
    localparam logic             POL      = (ACTIVE_LOW != 0);

    logic [DIV_W-1:0]      r_div;
    logic [IDX_W-1:0]      r_idx;
    logic [4*DIGITS-1:0]   r_pending;
    logic [DIGITS-1:0]     r_pending_dp;
    logic [4*DIGITS-1:0]   r_active;
    logic [DIGITS-1:0]     r_active_dp;
    logic [6:0]            r_seg;
    logic                  r_dp;
    logic [DIGITS-1:0]     r_an;
    logic                  r_frame_done;

    logic                  w_div_wrap;
    logic                  w_frame_wrap;
    logic [3:0]            w_code;
    logic                  w_dp_sel;
    logic                  w_lz_sel;
    logic                  w_zero_run;
    logic [6:0]            w_seg_act;
    logic [6:0]            w_seg_next;
    logic                  w_dp_next;
    logic [DIGITS-1:0]     w_an_next;
    logic                  w_ghost;

    assign w_div_wrap   = (r_div == DIV_LAST);
    assign w_frame_wrap = w_div_wrap && (r_idx == IDX_LAST);
    assign w_ghost      = (r_div == '0);

    // Slot divider and digit index; the index steps once per full slot
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div <= '0;
            r_idx <= '0;
        end else if (w_div_wrap) begin
            r_div <= '0;
            r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + IDX_W'(1);
        end else begin
            r_div <= r_div + DIV_W'(1);
        end
    end

    // Pending takes every load; active only changes at the frame boundary so a frame never tears
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pending    <= '0;
            r_pending_dp <= '0;
            r_active     <= '0;
            r_active_dp  <= '0;
        end else begin
            if (bus.load) begin
                r_pending    <= bus.bcd_in;
                r_pending_dp <= bus.dp_in;
            end
            if (w_frame_wrap) begin
                r_active    <= bus.load ? bus.bcd_in : r_pending;
                r_active_dp <= bus.load ? bus.dp_in  : r_pending_dp;
            end
        end
    end

    // Select the scanned digit and work out whether it sits in a run of leading zeros
    always_comb begin
        w_code     = '0;
        w_dp_sel   = 1'b0;
        w_lz_sel   = 1'b0;
        w_zero_run = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            w_zero_run = w_zero_run && (r_active[4*i +: 4] == 4'd0);
            if (r_idx == IDX_W'(i)) begin
                w_code   = r_active[4*i +: 4];
                w_dp_sel = r_active_dp[i];
                w_lz_sel = w_zero_run && (i > 0);
            end
        end
    end

    seg7_decode u_decode (
        .i_code      (w_code),
        .i_blank     (bus.blank_zero && w_lz_sel),
        .i_lamp_test (bus.lamp_test),
        .o_seg       (w_seg_act)
    );

    // Active-high pin values; the first cycle of each slot is dark so the old digit never ghosts
    always_comb begin
        w_seg_next = '0;
        w_dp_next  = 1'b0;
        w_an_next  = '0;
        if (!w_ghost) begin
            w_seg_next = w_seg_act;
            w_dp_next  = w_dp_sel || bus.lamp_test;
            w_an_next  = DIGITS'(1) << r_idx;
        end
    end

    // Output registers; polarity is applied only here
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_seg        <= {7{POL}};
            r_dp         <= POL;
            r_an         <= {DIGITS{POL}};
            r_frame_done <= 1'b0;
        end else begin
            r_seg        <= w_seg_next ^ {7{POL}};
            r_dp         <= w_dp_next ^ POL;
            r_an         <= w_an_next ^ {DIGITS{POL}};
            r_frame_done <= w_frame_wrap;
        end
    end

    assign bus.seg        = r_seg;
    assign bus.dp         = r_dp;
    assign bus.an         = r_an;
    assign bus.frame_done = r_frame_done;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb/tb_seg7_scan_driver.sv - self-checking bench for seg7_scan_driver
module tb_seg7_scan_driver;

    localparam int DIGITS   = 4;
    localparam int SCAN_DIV = 4;
    localparam int FRAME    = DIGITS * SCAN_DIV;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    seg7_scan_driver_if #(.DIGITS(DIGITS)) bus ();

    seg7_scan_driver #(
        .DIGITS     (DIGITS),
        .SCAN_DIV   (SCAN_DIV),
        .ACTIVE_LOW (1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    bit in_reset = 1'b1;

    bit hist_bz [4096];
    bit hist_lt [4096];
    int         ld_cyc [$];
    logic [15:0] ld_val [$];
    logic [3:0]  ld_dp  [$];

    function automatic logic [6:0] glyph(input logic [3:0] code);
        string s;
        logic [6:0] g;
        g = '0;
        case (code)
            4'd0:  s = "abcdef";
            4'd1:  s = "bc";
            4'd2:  s = "abdeg";
            4'd3:  s = "abcdg";
            4'd4:  s = "bcfg";
            4'd5:  s = "acdfg";
            4'd6:  s = "cdefg";
            4'd7:  s = "abc";
            4'd8:  s = "abcdefg";
            4'd9:  s = "abcfg";
            4'd10: s = "deg";
            4'd11: s = "cdg";
            4'd12: s = "bfg";
            4'd13: s = "adfg";
            4'd14: s = "defg";
            default: s = "";
        endcase
        for (int i = 0; i < s.len(); i++) begin
            g[int'(s.getc(i)) - 97] = 1'b1;
        end
        return g;
    endfunction

    task automatic frame_data(input int f, output logic [15:0] v, output logic [3:0] d);
        v = '0;
        d = '0;
        for (int k = 0; k < ld_cyc.size(); k++) begin
            if (ld_cyc[k] < f * FRAME) begin
                v = ld_val[k];
                d = ld_dp[k];
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_check();
        int c, slot, phase;
        logic [15:0] v;
        logic [3:0]  d;
        logic [6:0]  es;
        logic        edp;
        logic [3:0]  ean;
        logic        efd;
        c = cyc - 1;
        if (c < 0) return;
        phase = c % SCAN_DIV;
        slot  = (c / SCAN_DIV) % DIGITS;
        frame_data(c / FRAME, v, d);
        efd = ((c % FRAME) == FRAME - 1);
        if (phase == 0) begin
            es = 7'h7F; edp = 1'b1; ean = 4'hF;
        end else begin
            ean = ~(4'b0001 << slot);
            if (hist_lt[c % 4096]) begin
                es = 7'h00; edp = 1'b0;
            end else begin
                edp = ~d[slot];
                if (hist_bz[c % 4096] && slot > 0 && (v >> (4 * slot)) == 16'd0)
                    es = 7'h7F;
                else
                    es = ~glyph(v[4*slot +: 4]);
            end
        end
        chk("model_seg", 32'(bus.seg), 32'(es));
        chk("model_dp", 32'(bus.dp), 32'(edp));
        chk("model_an", 32'(bus.an), 32'(ean));
        chk("model_frame_done", 32'(bus.frame_done), 32'(efd));
    endtask

    task automatic tick();
        hist_bz[cyc % 4096] = bus.blank_zero;
        hist_lt[cyc % 4096] = bus.lamp_test;
        if (!in_reset && bus.load) begin
            ld_cyc.push_back(cyc);
            ld_val.push_back(bus.bcd_in);
            ld_dp.push_back(bus.dp_in);
        end
        @(posedge clk);
        #1;
        cyc++;
        if (!in_reset) model_check();
    endtask

    task automatic goto_phase(input int p);
        for (int n = 0; n < FRAME && (cyc % FRAME) != p; n++) tick();
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] d);
        bus.bcd_in = v;
        bus.dp_in  = d;
        bus.load   = 1'b1;
        tick();
        bus.load   = 1'b0;
    endtask

    task automatic release_reset();
        rst = 1'b0;
        cyc = 0;
        in_reset = 1'b0;
        ld_cyc.delete();
        ld_val.delete();
        ld_dp.delete();
    endtask

    initial begin
        bus.bcd_in = '0; bus.dp_in = '0; bus.load = 1'b0;
        bus.blank_zero = 1'b0; bus.lamp_test = 1'b0;

        // Reset state
        repeat (3) tick();
        chk("rst_seg", 32'(bus.seg), 32'h7F);
        chk("rst_dp", 32'(bus.dp), 32'h1);
        chk("rst_an", 32'(bus.an), 32'hF);
        chk("rst_frame_done", 32'(bus.frame_done), 32'h0);
        release_reset();
        tick();
        chk("first_ghost_an", 32'(bus.an), 32'hF);
        tick();
        chk("first_an", 32'(bus.an), 32'hE);

        // 1234 without blanking
        goto_phase(5);
        do_load(16'h1234, 4'h0);
        goto_phase(2);
        chk("d0_is_4", 32'(bus.seg), 32'h19);
        goto_phase(14);
        chk("d3_is_1", 32'(bus.seg), 32'h79);
        chk("d3_an", 32'(bus.an), 32'h7);
        repeat (FRAME) tick();

        // 0070 with and without leading-zero blanking
        bus.blank_zero = 1'b1;
        goto_phase(3);
        do_load(16'h0070, 4'b1000);
        goto_phase(2);
        chk("lz_d0", 32'(bus.seg), 32'h40);
        goto_phase(6);
        chk("lz_d1", 32'(bus.seg), 32'h78);
        goto_phase(10);
        chk("lz_d2", 32'(bus.seg), 32'h7F);
        goto_phase(14);
        chk("lz_d3", 32'(bus.seg), 32'h7F);
        chk("lz_d3_dp", 32'(bus.dp), 32'h0);
        bus.blank_zero = 1'b0;
        goto_phase(10);
        chk("nolz_d2", 32'(bus.seg), 32'h40);

        // Mid-frame load is deferred, boundary load is immediate
        goto_phase(4);
        do_load(16'h8888, 4'h0);
        goto_phase(2);
        do_load(16'h1111, 4'h0);
        goto_phase(14);
        chk("midload_old", 32'(bus.seg), 32'h00);
        goto_phase(2);
        chk("midload_new", 32'(bus.seg), 32'h79);
        goto_phase(15);
        do_load(16'h0009, 4'h0);
        goto_phase(2);
        chk("boundary_load", 32'(bus.seg), 32'h18);
        goto_phase(5);
        do_load(16'h5A3C, 4'h5);
        do_load(16'h6207, 4'h2);
        repeat (2 * FRAME) tick();

        // Lamp test over the blank code
        do_load(16'hFFFF, 4'h0);
        goto_phase(0);
        bus.lamp_test = 1'b1;
        goto_phase(6);
        chk("lamp_seg", 32'(bus.seg), 32'h00);
        chk("lamp_dp", 32'(bus.dp), 32'h0);
        bus.lamp_test = 1'b0;
        goto_phase(10);
        chk("unlamp_seg", 32'(bus.seg), 32'h7F);

        // Randomised traffic against the model
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 19) == 0) bus.blank_zero = $urandom_range(0, 1) != 0;
            if ($urandom_range(0, 29) == 0) bus.lamp_test = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 7) == 0) begin
                for (int k = 0; k < DIGITS; k++)
                    bus.bcd_in[4*k +: 4] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
                bus.dp_in = 4'($urandom_range(0, 15));
                bus.load  = 1'b1;
            end else begin
                bus.load  = 1'b0;
            end
            tick();
        end
        bus.load = 1'b0;
        bus.lamp_test = 1'b0;
        bus.blank_zero = 1'b0;

        // Asynchronous reset in the middle of slot 2
        do_load(16'h4321, 4'hF);
        repeat (FRAME) tick();
        goto_phase(9);
        #3;
        rst = 1'b1;
        in_reset = 1'b1;
        #1;
        chk("async_rst_seg", 32'(bus.seg), 32'h7F);
        chk("async_rst_dp", 32'(bus.dp), 32'h1);
        chk("async_rst_an", 32'(bus.an), 32'hF);
        repeat (2) tick();
        release_reset();
        repeat (2) tick();
        chk("restart_an", 32'(bus.an), 32'hE);
        chk("restart_seg", 32'(bus.seg), 32'h40);
        chk("restart_dp", 32'(bus.dp), 32'h1);
        repeat (FRAME + 2) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
